// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for the systolic array: per input-channel pass it loads weights, streams rows,
// then drains the array while issuing bias/obuf reads and obuf writes aligned to the array latency.
module systolic_tile_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int PIPE_LAT   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_num_ic,
  input  logic [CNT_WIDTH-1:0]  cfg_num_rows,
  input  logic [ADDR_WIDTH-1:0] cfg_ibuf_base,
  input  logic [ADDR_WIDTH-1:0] cfg_wbuf_base,
  input  logic [ADDR_WIDTH-1:0] cfg_obuf_base,
  input  logic                  cfg_bias_en,
  output logic                  busy,
  output logic                  done,
  output logic                  ibuf_read_req,
  output logic [ADDR_WIDTH-1:0] ibuf_read_addr,
  output logic                  wbuf_read_req,
  output logic [ADDR_WIDTH-1:0] wbuf_read_addr,
  output logic                  bbuf_read_req,
  output logic [ADDR_WIDTH-1:0] bbuf_read_addr,
  output logic                  obuf_read_req,
  output logic [ADDR_WIDTH-1:0] obuf_read_addr,
  output logic                  obuf_write_req,
  output logic [ADDR_WIDTH-1:0] obuf_write_addr,
  output logic                  acc_first,
  output logic                  acc_clear
);

  typedef enum logic [2:0] {S_IDLE, S_WGT, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_WIDTH-1:0]  r_num_ic;
  logic [CNT_WIDTH-1:0]  r_num_rows;
  logic [ADDR_WIDTH-1:0] r_wbuf_base;
  logic [ADDR_WIDTH-1:0] r_obuf_base;
  logic                  r_bias_en;
  logic [CNT_WIDTH-1:0]  r_ic;
  logic [CNT_WIDTH-1:0]  r_row;
  logic [CNT_WIDTH-1:0]  r_drain;
  logic [ADDR_WIDTH-1:0] r_ibuf_addr;
  logic [PIPE_LAT:1]     r_tag_vld;
  logic [PIPE_LAT:1]     r_tag_first;
  logic [CNT_WIDTH-1:0]  r_tag_row [1:PIPE_LAT];

  logic w_accept;
  logic w_last_row;
  logic w_last_drain;
  logic w_last_ic;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_last_row   = (r_row == r_num_rows - {{(CNT_WIDTH-1){1'b0}}, 1'b1});
  assign w_last_drain = (r_drain == CNT_WIDTH'(PIPE_LAT - 1));
  assign w_last_ic    = (r_ic == r_num_ic - {{(CNT_WIDTH-1){1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((cfg_num_ic == '0) || (cfg_num_rows == '0)) w_next_state = S_DONE;
          else                                            w_next_state = S_WGT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WGT:    w_next_state = S_STREAM;
      S_STREAM: w_next_state = w_last_row ? S_DRAIN : S_STREAM;
      S_DRAIN: begin
        if (w_last_drain) w_next_state = w_last_ic ? S_DONE : S_WGT;
        else              w_next_state = S_DRAIN;
      end
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // The ibuf address runs straight through all passes, which equals base + ic*R + r without a multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_ic    <= '0;
      r_num_rows  <= '0;
      r_wbuf_base <= '0;
      r_obuf_base <= '0;
      r_bias_en   <= 1'b0;
      r_ic        <= '0;
      r_row       <= '0;
      r_drain     <= '0;
      r_ibuf_addr <= '0;
    end else begin
      if (w_accept) begin
        r_num_ic    <= cfg_num_ic;
        r_num_rows  <= cfg_num_rows;
        r_wbuf_base <= cfg_wbuf_base;
        r_obuf_base <= cfg_obuf_base;
        r_bias_en   <= cfg_bias_en;
        r_ic        <= '0;
        r_row       <= '0;
        r_drain     <= '0;
        r_ibuf_addr <= cfg_ibuf_base;
      end
      if (r_state == S_STREAM) begin
        r_ibuf_addr <= r_ibuf_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        r_row       <= w_last_row ? '0 : r_row + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (r_state == S_DRAIN) begin
        r_drain <= w_last_drain ? '0 : r_drain + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        if (w_last_drain && !w_last_ic) r_ic <= r_ic + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_vld   <= '0;
      r_tag_first <= '0;
      for (int i = 1; i <= PIPE_LAT; i++) r_tag_row[i] <= '0;
    end else begin
      r_tag_vld[1]   <= (r_state == S_STREAM);
      r_tag_first[1] <= (r_ic == '0);
      r_tag_row[1]   <= r_row;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        r_tag_vld[i]   <= r_tag_vld[i-1];
        r_tag_first[i] <= r_tag_first[i-1];
        r_tag_row[i]   <= r_tag_row[i-1];
      end
    end
  end

  // Stage PIPE_LAT-1 fetches the accumulate operand one cycle ahead of the stage PIPE_LAT write.
  always_comb begin
    busy            = (r_state != S_IDLE);
    done            = (r_state == S_DONE);
    acc_clear       = (r_state == S_DONE);
    wbuf_read_req   = (r_state == S_WGT);
    wbuf_read_addr  = wbuf_read_req ? (r_wbuf_base + ADDR_WIDTH'(r_ic)) : '0;
    ibuf_read_req   = (r_state == S_STREAM);
    ibuf_read_addr  = ibuf_read_req ? r_ibuf_addr : '0;
    obuf_read_req   = r_tag_vld[PIPE_LAT-1] && !r_tag_first[PIPE_LAT-1];
    bbuf_read_req   = r_tag_vld[PIPE_LAT-1] && r_tag_first[PIPE_LAT-1] && r_bias_en;
    obuf_read_addr  = obuf_read_req ? (r_obuf_base + ADDR_WIDTH'(r_tag_row[PIPE_LAT-1])) : '0;
    bbuf_read_addr  = bbuf_read_req ? (r_obuf_base + ADDR_WIDTH'(r_tag_row[PIPE_LAT-1])) : '0;
    obuf_write_req  = r_tag_vld[PIPE_LAT];
    obuf_write_addr = obuf_write_req ? (r_obuf_base + ADDR_WIDTH'(r_tag_row[PIPE_LAT])) : '0;
    acc_first       = r_tag_vld[PIPE_LAT] && r_tag_first[PIPE_LAT];
  end

endmodule
